// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default operand width.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial WIDTH-bit subtractor (D = A - B - borrow_in), LSB first, start/done handshake.
// Define SUB_OVERFLOW_EN to build the signed-overflow output; otherwise ovf is tied low.
module serial_ripple_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             bor_q;
    logic [WIDTH-2:0] res_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] d_q;
    logic             bor_out_q;

    logic             bit_d;
    logic             bit_bout;
    logic [WIDTH-1:0] res_wide;
    logic [WIDTH-2:0] res_d;
    logic             accept;
    logic             last_step;

    full_subtractor_bit u_bit (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .bin_i  (bor_q),
        .d_o    (bit_d),
        .bout_o (bit_bout)
    );

    // The result reg holds only the first WIDTH-1 bits; the final bit joins them at DONE entry.
    assign res_wide  = {bit_d, res_q};
    assign res_d     = res_wide[WIDTH-1:1];
    assign accept    = (state_q == ST_IDLE) && start;
    assign last_step = (state_q == ST_SHIFT) && (cnt_q == LAST_STEP);

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            bor_q     <= 1'b0;
            res_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            d_q       <= '0;
            bor_out_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        a_q     <= a;
                        b_q     <= b;
                        bor_q   <= borrow_in;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    bor_q <= bit_bout;
                    res_q <= res_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_step) begin
                        state_q   <= ST_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        d_q       <= res_wide;
                        bor_out_q <= bit_bout;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign d          = d_q;
    assign borrow_out = bor_out_q;

`ifdef SUB_OVERFLOW_EN
    logic a_msb_q;
    logic b_msb_q;
    logic ovf_q;

    // Operand MSBs are shifted out during SHIFT, so they are captured at start.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                a_msb_q <= a[WIDTH-1];
                b_msb_q <= b[WIDTH-1];
            end
            if (last_step) begin
                ovf_q <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ bit_d);
            end
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor (WIDTH=4): vector table, scoreboard, corner sequences.
module tb_serial_ripple_subtractor;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] exp_d;
        logic         exp_bor;
        logic         exp_ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        logic         bor;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         borrow_out;
    logic         ovf;

    int   n_checks;
    int   n_errors;
    exp_t sb_q[$];
    exp_t last_res;

    serial_ripple_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .d          (d),
        .borrow_out (borrow_out),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ovf_if_en(input logic v);
`ifdef SUB_OVERFLOW_EN
        return v;
`else
        return 1'b0;
`endif
    endfunction

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        exp_t e;
        logic [W:0] full;
        full  = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi};
        e.d   = full[W-1:0];
        e.bor = full[W];
        e.ovf = ovf_if_en((av[W-1] ^ bv[W-1]) & (av[W-1] ^ full[W-1]));
        return e;
    endfunction

    task automatic compare_done(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_d"}, d, e.d);
            check({tag, "_borrow_out"}, borrow_out, e.bor);
            check({tag, "_ovf"}, ovf, e.ovf);
            last_res = e;
        end
    endtask

    // mode 0: plain op; 1: second start sampled at t+2; 2: rst sampled at t+3.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic bi, input exp_t e, input int mode);
        a = av;
        b = bv;
        borrow_in = bi;
        start = 1'b1;
        @(posedge clk);
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        borrow_in = 1'($urandom);
        for (int k = 0; k < 11; k++) begin
            if (mode == 2 && k == 3) begin
                check({tag, "_rst_busy"}, busy, 1'b0);
                check({tag, "_rst_d"}, d, '0);
                check({tag, "_rst_bor"}, borrow_out, 1'b0);
                check({tag, "_rst_done"}, done, 1'b0);
                rst = 1'b0;
                sb_q.delete();
                last_res = '{d: '0, bor: 1'b0, ovf: 1'b0};
            end else if (mode == 2 && k > 3) begin
                check({tag, "_no_done"}, done, 1'b0);
            end else if (k <= 3) begin
                check({tag, "_busy"}, busy, 1'b1);
                check({tag, "_early_done"}, done, 1'b0);
                check({tag, "_d_held"}, d, last_res.d);
            end else if (k == 4) begin
                check({tag, "_done_lat"}, done, 1'b1);
                check({tag, "_busy_off"}, busy, 1'b0);
                if (done) compare_done(tag);
            end else begin
                check({tag, "_done_pulse"}, done, 1'b0);
                check({tag, "_d_stable"}, d, last_res.d);
                break;
            end
            if (mode == 1 && k == 1) begin
                start = 1'b1;
                a = ~av;
                b = av;
                borrow_in = ~bi;
            end
            if (k == 2) start = 1'b0;
            if (mode == 2 && k == 2) rst = 1'b1;
            @(negedge clk);
        end
    endtask

    vec_t vecs[10];

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        last_res  = '{d: '0, bor: 1'b0, ovf: 1'b0};
        rst       = 1'b1;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        borrow_in = 1'b0;

        vecs[0] = '{a: 4'd7,  b: 4'd5,  bin: 1'b0, exp_d: 4'b0010, exp_bor: 1'b0, exp_ovf: 1'b0};
        vecs[1] = '{a: 4'd5,  b: 4'd7,  bin: 1'b0, exp_d: 4'b1110, exp_bor: 1'b1, exp_ovf: 1'b0};
        vecs[2] = '{a: 4'd15, b: 4'd10, bin: 1'b1, exp_d: 4'b0100, exp_bor: 1'b0, exp_ovf: 1'b0};
        vecs[3] = '{a: 4'd0,  b: 4'd15, bin: 1'b1, exp_d: 4'b0000, exp_bor: 1'b1, exp_ovf: 1'b0};
        vecs[4] = '{a: 4'd7,  b: 4'd8,  bin: 1'b0, exp_d: 4'b1111, exp_bor: 1'b1, exp_ovf: 1'b1};
        vecs[5] = '{a: 4'd8,  b: 4'd1,  bin: 1'b0, exp_d: 4'b0111, exp_bor: 1'b0, exp_ovf: 1'b1};
        vecs[6] = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, exp_d: 4'b1111, exp_bor: 1'b1, exp_ovf: 1'b0};
        for (int i = 7; i < 10; i++) begin
            exp_t e;
            vecs[i].a   = W'($urandom);
            vecs[i].b   = W'($urandom);
            vecs[i].bin = 1'($urandom);
            e = model(vecs[i].a, vecs[i].b, vecs[i].bin);
            vecs[i].exp_d   = e.d;
            vecs[i].exp_bor = e.bor;
            vecs[i].exp_ovf = e.ovf;
        end

        repeat (2) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_d", d, '0);
        check("reset_borrow_out", borrow_out, 1'b0);
        check("reset_ovf", ovf, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 1'b0);

        for (int i = 0; i < 10; i++) begin
            exp_t e;
            e.d   = vecs[i].exp_d;
            e.bor = vecs[i].exp_bor;
            e.ovf = ovf_if_en(vecs[i].exp_ovf);
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin, e, 0);
        end

        run_op("restart_ignored", 4'd7, 4'd5, 1'b0, model(4'd7, 4'd5, 1'b0), 1);
        check("restart_sb_drained", sb_q.size(), 0);

        run_op("rst_abort", 4'd5, 4'd7, 1'b0, model(4'd5, 4'd7, 1'b0), 2);
        run_op("after_abort", 4'd15, 4'd10, 1'b1, model(4'd15, 4'd10, 1'b1), 0);

        // start held high: accepts at relative edges 0 and 6, done at 4 and 10.
        a = 4'd9;
        b = 4'd3;
        borrow_in = 1'b1;
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            if (k == 0 || k == 6) sb_q.push_back(model(4'd9, 4'd3, 1'b1));
            check($sformatf("cont_done_k%0d", k), done, (k == 4 || k == 10) ? 1'b1 : 1'b0);
            if (done) compare_done("cont");
        end
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("final_sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
